// File: rtl/wave_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : wave_sequencer
// Brief    : Plays an 8-entry programmable table of {wave, freq, duration}
//            steps to a waveform generator, paced by a prescaler tick.
// Revision : 1.0
// =============================================================================
module wave_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_tick,
   input  logic        i_start,
   input  logic        i_stop,
   input  logic        i_loop_en,
   input  logic [2:0]  i_last_idx,
   input  logic        i_prog_we,
   input  logic [2:0]  i_prog_addr,
   input  logic [15:0] i_prog_data,
   output logic [1:0]  o_wave_sel,
   output logic [5:0]  o_freq_sel,
   output logic        o_cfg_valid,
   output logic        o_wave_en,
   output logic [2:0]  o_step_idx,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_table [8];
   logic [2:0]  r_step, w_step_nxt;
   logic [1:0]  r_wave, w_wave_nxt;
   logic [5:0]  r_freq, w_freq_nxt;
   logic [7:0]  r_dur, w_dur_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic        r_cfg, w_cfg_nxt;
   logic        r_en, w_en_nxt;
   logic        r_done, w_done_nxt;

   logic [15:0] w_entry;
   logic [7:0]  w_cnt_inc;
   logic        w_entry_end;
   logic        w_is_last;

   assign w_entry     = r_table[r_step];
   assign w_cnt_inc   = r_cnt + 8'd1;
   // 8-bit wrap makes a stored duration of 0 end after 256 ticks
   assign w_entry_end = i_tick && (w_cnt_inc == r_dur);
   assign w_is_last   = (r_step >= i_last_idx);

   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_wave_nxt  = r_wave;
      w_freq_nxt  = r_freq;
      w_dur_nxt   = r_dur;
      w_cnt_nxt   = r_cnt;
      w_en_nxt    = r_en;
      w_cfg_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start && !i_stop) begin
               w_step_nxt  = 3'd0;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (i_stop) begin
               w_en_nxt    = 1'b0;
               w_state_nxt = S_IDLE;
            end else begin
               w_wave_nxt  = w_entry[15:14];
               w_freq_nxt  = w_entry[13:8];
               w_dur_nxt   = w_entry[7:0];
               w_cnt_nxt   = 8'd0;
               w_cfg_nxt   = 1'b1;
               w_en_nxt    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (i_stop) begin
               w_en_nxt    = 1'b0;
               w_state_nxt = S_IDLE;
            end else if (i_tick) begin
               w_cnt_nxt = w_cnt_inc;
               if (w_entry_end) begin
                  if (!w_is_last) begin
                     w_step_nxt  = r_step + 3'd1;
                     w_state_nxt = S_LOAD;
                  end else if (i_loop_en) begin
                     w_step_nxt  = 3'd0;
                     w_state_nxt = S_LOAD;
                  end else begin
                     w_done_nxt  = 1'b1;
                     w_en_nxt    = 1'b0;
                     w_state_nxt = S_IDLE;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_step  <= 3'd0;
         r_wave  <= 2'd0;
         r_freq  <= 6'd0;
         r_dur   <= 8'd0;
         r_cnt   <= 8'd0;
         r_cfg   <= 1'b0;
         r_en    <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;
         r_wave  <= w_wave_nxt;
         r_freq  <= w_freq_nxt;
         r_dur   <= w_dur_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cfg   <= w_cfg_nxt;
         r_en    <= w_en_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Applied entry lives in r_wave/r_freq/r_dur, so table writes only affect later loads
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            r_table[i] <= 16'd0;
         end
      end else if (i_prog_we) begin
         r_table[i_prog_addr] <= i_prog_data;
      end
   end

   assign o_wave_sel  = r_wave;
   assign o_freq_sel  = r_freq;
   assign o_cfg_valid = r_cfg;
   assign o_wave_en   = r_en;
   assign o_step_idx  = r_step;
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = r_done;

endmodule
`default_nettype wire
